// File: rtl/rv32_e_div_sequencer.sv
// rv32_e_div_sequencer
// Execute-stage sequencer for the RV32M divide group (DIV/DIVU/REM/REMU).
// Radix-2 restoring division, one quotient bit per cycle. The pipeline is
// stalled while the op iterates, and one result is presented with a
// single-cycle valid_o pulse. Divide-by-zero and signed overflow are
// resolved in one cycle without iterating.
module rv32_e_div_sequencer #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  state_t            state;
  logic [1:0]        funct3;     // bit1 = remainder select, bit0 = unsigned
  logic [XLEN-1:0]   dvd;        // dividend, shifted into quotient bit by bit
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   rem;
  logic [CNT_W-1:0]  cnt;
  logic              sign_q;
  logic              sign_r;

  // funct3[2] is always 1 for this unit; the pipeline only starts divide ops
  logic              unused_funct3;
  assign unused_funct3 = funct3_i[2];

  // Accept decision and special-case detection on the raw inputs
  logic              accept;
  logic              in_signed;
  logic              div_zero;
  logic              overflow;
  logic [XLEN-1:0]   special_q;
  logic [XLEN-1:0]   special_r;
  logic [XLEN-1:0]   special_res;

  assign accept      = start_i & ~flush_i;
  assign in_signed   = ~funct3_i[0];
  assign div_zero    = (op_b_i == '0);
  assign overflow    = in_signed & (op_a_i == INT_MIN) & (op_b_i == ALL_ONES);
  assign special_q   = div_zero ? ALL_ONES : INT_MIN;
  assign special_r   = div_zero ? op_a_i : '0;
  assign special_res = funct3_i[1] ? special_r : special_q;

  // One restoring step: XLEN+1-bit trial subtraction, MSB is the borrow
  logic [XLEN:0]     trial;
  assign trial = {rem, dvd[XLEN-1]} - {1'b0, divisor};

  // Sign handling for the PREP and FIX stages
  logic              op_signed;
  logic [XLEN-1:0]   quot_fixed;
  logic [XLEN-1:0]   rem_fixed;
  assign op_signed  = ~funct3[0];
  assign quot_fixed = sign_q ? (~dvd + 1'b1) : dvd;
  assign rem_fixed  = sign_r ? (~rem + 1'b1) : rem;

  // Stall request: combinational, held low while in reset
  always_comb begin
    stall_o = 1'b0;
    unique case (state)
      IDLE:            stall_o = accept;
      PREP, CALC, FIX: stall_o = 1'b1;
      default:         stall_o = 1'b0;
    endcase
    stall_o = stall_o & rst_ni;
  end

  assign busy_o = (state != IDLE);

  // Sequencer FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      funct3   <= '0;
      dvd      <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      // A flush in DONE is harmless: valid_o was already presented
      state   <= IDLE;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            funct3  <= funct3_i[1:0];
            dvd     <= op_a_i;
            divisor <= op_b_i;
            if (div_zero || overflow) begin
              result_o <= special_res;
              valid_o  <= 1'b1;
              state    <= DONE;
            end else begin
              state <= PREP;
            end
          end
        end
        PREP: begin
          // Iterate on magnitudes; signs are reapplied in FIX
          sign_q <= op_signed & (dvd[XLEN-1] ^ divisor[XLEN-1]);
          sign_r <= op_signed & dvd[XLEN-1];
          if (op_signed && dvd[XLEN-1]) dvd <= ~dvd + 1'b1;
          if (op_signed && divisor[XLEN-1]) divisor <= ~divisor + 1'b1;
          rem   <= '0;
          cnt   <= CNT_W'(XLEN);
          state <= CALC;
        end
        CALC: begin
          if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            dvd <= {dvd[XLEN-2:0], 1'b1};
          end else begin
            rem <= {rem[XLEN-2:0], dvd[XLEN-1]};
            dvd <= {dvd[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          result_o <= funct3[1] ? rem_fixed : quot_fixed;
          valid_o  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_e_div_sequencer.sv
// tb_rv32_e_div_sequencer
// Scoreboarded bench: the driver pushes the expected result and the cycle
// on which it must appear; a monitor pops and compares on every valid_o.
module tb_rv32_e_div_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'b100;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        stall_o;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  rv32_e_div_sequencer #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: RISC-V M-extension divide semantics on plain integers
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3[1:0])
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 35;
  endfunction

  // Monitor: every valid_o must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (rst_ni && valid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_valid: got result %h with no op outstanding (cycle %0d)", result_o, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (result_o !== e.res || cyc != e.due) begin
          failed++;
          $display("FAIL result f3=%b a=%h b=%h: got %h at cycle %0d, required %h at cycle %0d",
                   e.f3, e.a, e.b, result_o, cyc, e.res, e.due);
        end
        check("stall_in_done", {31'b0, stall_o}, 32'd0);
      end
      $display("[TB] op done result=%h cycle=%0d", result_o, cyc);
    end
  end

  // Issue one op at a negedge; optionally track it and wait for completion
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit track);
    int n;
    @(negedge clk_i);
    n = 0;
    while ((busy_o || valid_o) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
    start_i  = 1'b1;
    if (track) begin
      exp_t e;
      e.res = ref_result(f3, a, b);
      e.due = cyc + ref_latency(f3, a, b);
      e.f3  = f3;
      e.a   = a;
      e.b   = b;
      exp_q.push_back(e);
    end
    #1;
    check("stall_on_start", {31'b0, stall_o}, 32'd1);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    if (track) begin
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
        @(negedge clk_i);
        #1;
        n++;
      end
      if (exp_q.size() != 0) begin
        tests++;
        failed++;
        $display("FAIL timeout: op f3=%b a=%h b=%h produced no valid_o within 60 cycles", f3, a, b);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;

    // Reset state
    #1;
    check("reset_busy",   {31'b0, busy_o},  32'd0);
    check("reset_valid",  {31'b0, valid_o}, 32'd0);
    check("reset_result", result_o,         32'd0);
    check("reset_stall",  {31'b0, stall_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed cases
    run_op(3'b100, 32'd100, 32'd7, 1);
    run_op(3'b110, 32'd100, 32'd7, 1);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(3'b101, 32'd5, 32'd0, 1);
    run_op(3'b111, 32'd5, 32'd0, 1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(3'b101, 32'hFFFF_FFF9, 32'hFFFF_FFF0, 1);
    run_op(3'b111, 32'hFFFF_FFF9, 32'h8000_0001, 1);
    run_op(3'b100, 32'h8000_0000, 32'd3, 1);
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 1);

    // Flush in the middle of a DIV: no result, back to IDLE
    run_op(3'b100, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    check("busy_before_flush", {31'b0, busy_o}, 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    check("flush_busy",  {31'b0, busy_o},  32'd0);
    check("flush_stall", {31'b0, stall_o}, 32'd0);
    check("flush_valid", {31'b0, valid_o}, 32'd0);
    repeat (40) @(negedge clk_i);
    run_op(3'b100, 32'd100, 32'd7, 1);

    // flush_i has priority over start_i in IDLE
    @(negedge clk_i);
    start_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("flush_prio_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    check("flush_prio_busy", {31'b0, busy_o}, 32'd0);

    // Reset mid-operation: outputs clear at once, next op accepted
    run_op(3'b100, 32'd999, 32'd4, 0);
    repeat (19) @(negedge clk_i);
    rst_ni   = 1'b0;
    start_i  = 1'b1;
    #1;
    check("midreset_busy",   {31'b0, busy_o},  32'd0);
    check("midreset_valid",  {31'b0, valid_o}, 32'd0);
    check("midreset_result", result_o,         32'd0);
    check("midreset_stall",  {31'b0, stall_o}, 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    rst_ni = 1'b1;
    run_op(3'b110, 32'd100, 32'd7, 1);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = -32'($urandom_range(1, 100));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = $urandom >> $urandom_range(0, 31);
        4:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(f3, a, b, 1);
    end

    repeat (5) @(negedge clk_i);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
